fp_result_pack: RTL and testbench

- Output-side counterpart of the FP classifier. Takes an unpacked, unrounded single-precision result from the FPU datapath (sign, wide signed biased exponent, mantissa with guard/round/sticky) and produces the packed IEEE-754 word.
- Rounds to nearest-even, saturates out-of-range exponents to Inf or signed zero, and raises overflow/underflow/inexact event flags.
- Two-stage valid/ready pipeline between the arithmetic core and the result writeback.

---
 rtl/fp_result_pack.sv | 83 ++++++++
 tb/tb_fp_result_pack.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp_result_pack.sv
// fp_result_pack: rounds an unpacked single-precision result to nearest-even and packs it into an IEEE-754 word.
module fp_result_pack #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [26:0]      in_mant,
  input  logic             in_nan,
  input  logic             in_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);
  localparam logic signed [EXP_W:0] EXP_MAX = 255;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic s1_sign, s1_inexact, s1_zero, s1_nan, s1_inf;
  logic signed [EXP_W:0] s1_exp, r_exp;
  logic [22:0] s1_frac, r_frac;
  logic [24:0] r_sum;
  logic r_inc, p_norm, p_ovf, p_unf, p_inx;
  logic [31:0] p_data;
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  // Round half to even on the 24-bit significand; a carry out renormalises by one place.
  always_comb begin
    r_inc = in_mant[2] & (in_mant[1] | in_mant[0] | in_mant[3]);
    r_sum = {1'b0, in_mant[26:3]} + {24'd0, r_inc};
    r_frac = r_sum[24] ? r_sum[23:1] : r_sum[22:0];
    r_exp = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, r_sum[24]};
  end
  always_comb begin
    p_norm = !s1_nan && !s1_inf && !s1_zero;
    p_ovf = p_norm && (s1_exp >= EXP_MAX);
    p_unf = p_norm && (s1_exp[EXP_W] || s1_exp == '0);
    p_inx = p_ovf || p_unf || (p_norm && s1_inexact);
    p_data = s1_nan ? 32'h7FC0_0000 :
             (s1_inf || p_ovf) ? {s1_sign, 8'hFF, 23'd0} :
             (s1_zero || p_unf) ? {s1_sign, 31'd0} :
             {s1_sign, s1_exp[7:0], s1_frac};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_sign <= in_sign;
      s1_exp <= r_exp;
      s1_frac <= r_frac;
      s1_inexact <= |in_mant[2:0];
      s1_zero <= in_mant == '0;
      s1_nan <= in_nan;
      s1_inf <= in_inf;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_overflow <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_data <= p_data;
      out_overflow <= p_ovf;
      out_underflow <= p_unf;
      out_inexact <= p_inx;
    end
  end
endmodule

// File: tb/tb_fp_result_pack.sv
// tb_fp_result_pack: directed and randomized checks of fp_result_pack against an arithmetic reference model.
module tb_fp_result_pack;
  localparam int EXP_W = 10;
  logic clk = 0, rst = 1, in_valid = 0, in_sign = 0, in_nan = 0, in_inf = 0, out_ready = 1;
  logic [EXP_W-1:0] in_exp = '0;
  logic [26:0] in_mant = '0;
  logic in_ready, out_valid, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_data;
  int n_vec = 0, n_bad = 0, n_in = 0;
  logic [34:0] sb[$];
  logic [34:0] pend = '0;
  fp_result_pack #(.EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_nan(in_nan), .in_inf(in_inf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // Value-level model: the 24-bit significand is an integer, the remainder decides rounding.
  function automatic logic [34:0] model(input logic s, input logic [EXP_W-1:0] ex, input logic [26:0] mt,
                                        input logic nn, input logic nf);
    int e = int'($signed(ex));
    int m = int'(mt[26:3]);
    int rem = int'(mt[2:0]);
    if (nn) return {32'h7FC0_0000, 3'b000};
    if (nf) return {s, 8'hFF, 23'd0, 3'b000};
    if (mt == 0) return {s, 31'd0, 3'b000};
    if (rem > 4 || (rem == 4 && m % 2 == 1)) m = m + 1;
    if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (e <= 0) return {s, 31'd0, 3'b011};
    return {s, 8'(e), 23'(m % (1 << 23)), 2'b00, rem != 0};
  endfunction
  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      sb.push_back(pend);
      n_in++;
    end
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $error("FAIL spurious_out: observed %h expected no beat", out_data);
      end else chk("out_beat", {out_data, out_overflow, out_underflow, out_inexact}, sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input int e, input logic [26:0] m, input logic nn, input logic nf,
                       input logic [34:0] ev);
    in_sign = s;
    in_exp = e[EXP_W-1:0];
    in_mant = m;
    in_nan = nn;
    in_inf = nf;
    pend = ev;
  endtask
  task automatic send(input logic s, input int e, input logic [26:0] m, input logic nn, input logic nf,
                      input logic [34:0] ev);
    int start = n_in;
    drive(s, e, m, nn, nf, ev);
    in_valid = 1;
    for (int k = 0; k < 20 && n_in == start; k++) step();
    in_valid = 0;
    if (n_in == start) chk("send_timeout", 35'(n_in - start), 35'd1);
  endtask
  task automatic drain();
    for (int k = 0; k < 50 && sb.size() > 0; k++) step();
    chk("drain_empty", 35'(sb.size()), 35'd0);
    sb.delete();
  endtask
  logic cs, cn, ci;
  int ce;
  logic [26:0] cm;
  task automatic gen();
    int sel = $urandom_range(0, 9);
    int ms = $urandom_range(0, 15);
    cs = 1'($urandom);
    ce = sel == 0 ? int'($urandom_range(0, 1023)) : sel == 1 ? 254 : sel == 2 ? 255 :
         sel == 3 ? 1 : sel == 4 ? 0 : int'($urandom_range(100, 160));
    cm = ms == 0 ? 27'd0 : ms < 3 ? {1'b1, 23'h7FFFFF, 3'($urandom)} : {1'b1, 26'($urandom)};
    cn = $urandom_range(0, 31) == 0;
    ci = $urandom_range(0, 31) == 0;
    drive(cs, ce, cm, cn, ci, model(cs, ce[EXP_W-1:0], cm, cn, ci));
  endtask
  logic [31:0] hold;
  int base;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", 35'(out_valid), 35'd0);
    chk("rst_out_data", {out_data, out_overflow, out_underflow, out_inexact}, 35'd0);
    chk("rst_in_ready", 35'(in_ready), 35'd1);
    send(0, 127, 27'h4000000, 0, 0, {32'h3F80_0000, 3'b000});
    chk("lat_1cyc", 35'(out_valid), 35'd0);
    step();
    chk("lat_2cyc", 35'(out_valid), 35'd1);
    drain();
    send(0, 127, {1'b1, 23'h000001, 3'b100}, 0, 0, {32'h3F80_0002, 3'b001});
    send(0, 127, {1'b1, 23'h000000, 3'b100}, 0, 0, {32'h3F80_0000, 3'b001});
    send(0, 127, {1'b1, 23'h7FFFFF, 3'b110}, 0, 0, {32'h4000_0000, 3'b001});
    send(0, 254, {1'b1, 23'h7FFFFF, 3'b100}, 0, 0, {32'h7F80_0000, 3'b101});
    send(1, 300, 27'h4000000, 0, 0, {32'hFF80_0000, 3'b101});
    send(1, 0, 27'h4000000, 0, 0, {32'h8000_0000, 3'b011});
    send(0, -5, 27'h4000001, 0, 0, {32'h0000_0000, 3'b011});
    send(0, 0, 27'd0, 0, 0, {32'h0000_0000, 3'b000});
    send(1, 300, 27'd0, 0, 0, {32'h8000_0000, 3'b000});
    send(1, 127, 27'h4000005, 1, 0, {32'h7FC0_0000, 3'b000});
    send(1, 127, 27'h4000005, 1, 1, {32'h7FC0_0000, 3'b000});
    send(1, -3, 27'h4000005, 0, 1, {32'hFF80_0000, 3'b000});
    send(0, 1, 27'h4000000, 0, 0, {32'h0080_0000, 3'b000});
    drain();
    out_ready = 0;
    base = n_in;
    for (int k = 0; k < 6; k++) begin
      if (n_in - base < 4) begin
        drive(0, 120 + n_in - base, {1'b1, 26'($urandom)}, 0, 0, '0);
        pend = model(in_sign, in_exp, in_mant, 0, 0);
        in_valid = 1;
      end else in_valid = 0;
      step();
    end
    chk("bp_accepted", 35'(n_in - base), 35'd2);
    chk("bp_in_ready", 35'(in_ready), 35'd0);
    chk("bp_out_valid", 35'(out_valid), 35'd1);
    hold = out_data;
    step();
    step();
    chk("bp_stable", 35'(out_data), 35'(hold));
    out_ready = 1;
    for (int k = 0; k < 30 && (n_in - base < 4 || sb.size() > 0); k++) begin
      if (n_in - base < 4) begin
        drive(0, 120 + n_in - base, {1'b1, 26'($urandom)}, 0, 0, '0);
        pend = model(in_sign, in_exp, in_mant, 0, 0);
        in_valid = 1;
      end else in_valid = 0;
      step();
    end
    in_valid = 0;
    chk("bp_all_in", 35'(n_in - base), 35'd4);
    chk("bp_drained", 35'(sb.size()), 35'd0);
    gen();
    in_valid = 1;
    step();
    gen();
    step();
    in_valid = 0;
    rst = 1;
    #2;
    chk("midrst_out_valid", 35'(out_valid), 35'd0);
    sb.delete();
    step();
    rst = 0;
    chk("midrst_in_ready", 35'(in_ready), 35'd1);
    chk("midrst_out_data", 35'(out_data), 35'd0);
    repeat (4) step();
    chk("midrst_idle", 35'(out_valid), 35'd0);
    base = n_in;
    gen();
    for (int k = 0; k < 4000 && n_in - base < 300; k++) begin
      int prev = n_in;
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 3) != 0;
      step();
      if (n_in != prev) gen();
    end
    in_valid = 0;
    out_ready = 1;
    chk("rand_count", 35'(n_in - base), 35'd300);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
